// File: rtl/rr_arbiter_4x1.sv
// Four-requester round-robin bus arbiter with atomic lock, abandon detection
// and a bus timeout that forces a DEAD_BEEF completion back to the requester.
module rr_arbiter_4x1 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [3:0]   i_bus_en,
  input  logic [3:0]   i_wr_rd,
  input  logic [127:0] i_wr_data,
  input  logic [127:0] i_addr,
  input  logic [15:0]  i_byte_en,
  input  logic [3:0]   i_atomic,
  output logic [3:0]   o_ack,
  output logic [127:0] o_rd_data,
  input  logic         i_ack,
  input  logic [31:0]  i_rd_data,
  output logic         o_bus_en,
  output logic         o_wr_en,
  output logic         o_atomic,
  output logic [31:0]  o_wr_data,
  output logic [31:0]  o_addr,
  output logic [3:0]   o_byte_en,
  output logic [1:0]   o_id,
  output logic         o_timeout_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_TURN = 2'd2;

  localparam logic [7:0]  TCNT_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  logic [1:0] state_q, state_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [7:0] tcnt_q,  tcnt_d;
  logic [1:0] id_q,    id_d;

  logic       any_req;
  logic       found;
  logic [1:0] cand;
  logic [1:0] winner;
  logic       cur_req;
  logic       cur_atomic;
  logic       timeout_hit;

  // Search starts one past the last winner so the previous owner is tried last.
  always_comb begin
    any_req = |i_bus_en;
    winner  = ptr_q;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = 2'(32'(ptr_q) + i);
      if (!found && i_bus_en[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign cur_req     = i_bus_en[id_q];
  assign cur_atomic  = i_atomic[id_q];
  // A dropped request counts as abandonment and never reports a timeout.
  assign timeout_hit = (state_q == ST_BUSY) && !i_ack && cur_req &&
                       (tcnt_q == TCNT_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tcnt_d  = tcnt_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          id_d    = winner;
          ptr_d   = winner;
          tcnt_d  = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_ack) begin
          tcnt_d = '0;
          if (!cur_atomic) begin
            state_d = ST_TURN;
          end
        end else if (!cur_req) begin
          state_d = ST_TURN;
        end else if (timeout_hit) begin
          state_d = ST_TURN;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd3;
      tcnt_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    o_bus_en      = 1'b0;
    o_wr_en       = 1'b0;
    o_atomic      = 1'b0;
    o_wr_data     = '0;
    o_addr        = '0;
    o_byte_en     = '0;
    o_ack         = '0;
    o_rd_data     = '0;
    o_timeout_err = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (state_q == ST_BUSY && id_q == 2'(k)) begin
        o_bus_en  = i_bus_en[k];
        o_wr_en   = i_wr_rd[k];
        o_atomic  = i_atomic[k];
        o_wr_data = i_wr_data[32*k +: 32];
        o_addr    = i_addr[32*k +: 32];
        o_byte_en = i_byte_en[4*k +: 4];
        if (i_ack) begin
          o_ack[k]              = 1'b1;
          o_rd_data[32*k +: 32] = i_rd_data;
        end else if (timeout_hit) begin
          o_ack[k]              = 1'b1;
          o_rd_data[32*k +: 32] = ABORT_DATA;
          o_timeout_err         = 1'b1;
        end
      end
    end
  end

  assign o_id = id_q;

endmodule

// File: tb/tb_rr_arbiter_4x1.sv
// Self-checking bench for rr_arbiter_4x1: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_rr_arbiter_4x1;

  localparam int TMO = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   bus_en;
  logic [3:0]   wr_rd;
  logic [127:0] wr_data;
  logic [127:0] addr;
  logic [15:0]  byte_en;
  logic [3:0]   atomic;
  logic         ack_in;
  logic [31:0]  rd_in;
  logic [3:0]   o_ack;
  logic [127:0] o_rd_data;
  logic         o_bus_en, o_wr_en, o_atomic, o_timeout_err;
  logic [31:0]  o_wr_data, o_addr;
  logic [3:0]   o_byte_en;
  logic [1:0]   o_id;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int   m_owner;   // -1 when nobody holds the bus
  bit   m_gap;     // turnaround cycle pending
  int   m_waited;
  int   m_last;
  logic [1:0] m_id;

  rr_arbiter_4x1 #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_bus_en(bus_en), .i_wr_rd(wr_rd),
    .i_wr_data(wr_data), .i_addr(addr), .i_byte_en(byte_en), .i_atomic(atomic),
    .o_ack(o_ack), .o_rd_data(o_rd_data), .i_ack(ack_in), .i_rd_data(rd_in),
    .o_bus_en(o_bus_en), .o_wr_en(o_wr_en), .o_atomic(o_atomic),
    .o_wr_data(o_wr_data), .o_addr(o_addr), .o_byte_en(o_byte_en),
    .o_id(o_id), .o_timeout_err(o_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [203:0] all_outs();
    return {o_bus_en, o_wr_en, o_atomic, o_wr_data, o_addr, o_byte_en,
            o_ack, o_rd_data, o_timeout_err};
  endfunction

  task automatic set_fields();
    for (int k = 0; k < 4; k++) begin
      addr[32*k +: 32]    = 32'hA000_0000 + k;
      wr_data[32*k +: 32] = 32'hD000_0000 + k;
      byte_en[4*k +: 4]   = 4'h1 << k;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus_en = '0; wr_rd = '0; atomic = '0; ack_in = 1'b0; rd_in = '0;
    set_fields();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_owner = -1; m_gap = 0; m_waited = 0; m_last = 3; m_id = 2'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus_en = 4'hF; ack_in = 1'b1; rd_in = 32'h1234_5678;
    #1;
    checks++;
    if (all_outs() !== '0 || o_id !== 2'd0) begin
      failures++; $display("FAIL reset_outputs got=%h id=%0d want=0", all_outs(), o_id);
    end
    do_reset();
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++; $display("FAIL reset_idle got=%h want=0", all_outs());
    end
    @(negedge clk);
  endtask

  task automatic test_priority();
    do_reset();
    bus_en = 4'b1010; #1;
    checks++;
    if (o_bus_en !== 1'b0) begin
      failures++; $display("FAIL prio_latency bus_en=%b want=0", o_bus_en);
    end
    @(negedge clk); #1;
    checks++;
    if (o_id !== 2'd1 || o_bus_en !== 1'b1 || o_addr !== 32'hA000_0001) begin
      failures++; $display("FAIL prio_grant1 id=%0d bus=%b addr=%h want 1,1,a0000001", o_id, o_bus_en, o_addr);
    end
    ack_in = 1'b1; rd_in = 32'h0BAD_F00D; #1;
    checks++;
    if (o_ack !== 4'b0010 || o_rd_data !== {64'h0, 32'h0BAD_F00D, 32'h0}) begin
      failures++; $display("FAIL prio_ack ack=%b rd=%h", o_ack, o_rd_data);
    end
    @(negedge clk); ack_in = 1'b0; bus_en = 4'b1000; #1;
    checks++;
    if (o_bus_en !== 1'b0 || o_ack !== 4'b0 || o_id !== 2'd1) begin
      failures++; $display("FAIL prio_turn bus=%b ack=%b id=%0d want 0,0,1", o_bus_en, o_ack, o_id);
    end
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (o_id !== 2'd3 || o_bus_en !== 1'b1 || o_addr !== 32'hA000_0003) begin
      failures++; $display("FAIL prio_grant3 id=%0d bus=%b addr=%h want 3,1,a0000003", o_id, o_bus_en, o_addr);
    end
    ack_in = 1'b1;
    @(negedge clk); ack_in = 1'b0; bus_en = '0;
    @(negedge clk);
  endtask

  task automatic test_rotation();
    int grants[$];
    bit prev_busy;
    do_reset();
    bus_en = 4'hF; ack_in = 1'b1; rd_in = 32'h5555_AAAA;
    prev_busy = 0;
    for (int c = 0; c < 30 && grants.size() < 6; c++) begin
      #1;
      if (o_bus_en) begin
        grants.push_back(int'(o_id));
        checks++;
        if (prev_busy || o_ack !== (4'b0001 << o_id)) begin
          failures++; $display("FAIL rot_ack_turn id=%0d ack=%b back_to_back=%0d", o_id, o_ack, prev_busy);
        end
      end
      prev_busy = o_bus_en;
      @(negedge clk);
    end
    checks++;
    if (grants.size() < 5) begin
      failures++; $display("FAIL rot_count got=%0d want>=5", grants.size());
    end else begin
      for (int g = 0; g < 5; g++) begin
        checks++;
        if (grants[g] != g % 4) begin
          failures++; $display("FAIL rot_order idx=%0d got=%0d want=%0d", g, grants[g], g % 4);
        end
      end
    end
    ack_in = 1'b0; bus_en = '0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_atomic();
    logic [31:0] rv [3];
    rv[0] = 32'h1111_0001; rv[1] = 32'h2222_0002; rv[2] = 32'h3333_0003;
    do_reset();
    bus_en = 4'b0100; wr_rd = 4'b0000; atomic = 4'b0100;
    @(negedge clk);
    bus_en = 4'b0101;
    for (int p = 0; p < 3; p++) begin
      if (p == 2) atomic = 4'b0000;
      ack_in = 1'b1; rd_in = rv[p]; #1;
      checks++;
      if (o_id !== 2'd2 || o_bus_en !== 1'b1 || o_wr_en !== 1'b0 || o_ack !== 4'b0100 ||
          o_rd_data !== {32'h0, rv[p], 64'h0}) begin
        failures++; $display("FAIL atomic_beat%0d id=%0d bus=%b wr=%b ack=%b rd=%h", p, o_id, o_bus_en, o_wr_en, o_ack, o_rd_data);
      end
      @(negedge clk);
    end
    ack_in = 1'b0; bus_en = 4'b0001; #1;
    checks++;
    if (o_bus_en !== 1'b0 || o_ack !== 4'b0) begin
      failures++; $display("FAIL atomic_turn bus=%b ack=%b want 0,0", o_bus_en, o_ack);
    end
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (o_id !== 2'd0 || o_bus_en !== 1'b1) begin
      failures++; $display("FAIL atomic_next id=%0d bus=%b want 0,1", o_id, o_bus_en);
    end
    bus_en = '0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    bus_en = 4'b0001; ack_in = 1'b0;
    @(negedge clk);
    for (int c = 1; c < TMO; c++) begin
      #1;
      checks++;
      if (o_ack !== 4'b0 || o_timeout_err !== 1'b0 || o_bus_en !== 1'b1) begin
        failures++; $display("FAIL tmo_wait%0d ack=%b err=%b bus=%b", c, o_ack, o_timeout_err, o_bus_en);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (o_ack !== 4'b0001 || o_rd_data[31:0] !== 32'hDEAD_BEEF || o_timeout_err !== 1'b1) begin
      failures++; $display("FAIL tmo_abort ack=%b rd=%h err=%b want 0001,deadbeef,1", o_ack, o_rd_data[31:0], o_timeout_err);
    end
    @(negedge clk); bus_en = '0; #1;
    checks++;
    if (o_timeout_err !== 1'b0 || o_bus_en !== 1'b0 || o_ack !== 4'b0) begin
      failures++; $display("FAIL tmo_turn err=%b bus=%b ack=%b want 0", o_timeout_err, o_bus_en, o_ack);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_en = 4'b1000; wr_rd = 4'b1000;
    @(negedge clk); #1;
    checks++;
    if (o_id !== 2'd3 || o_wr_en !== 1'b1) begin
      failures++; $display("FAIL rstmid_grant id=%0d wr=%b want 3,1", o_id, o_wr_en);
    end
    ack_in = 1'b1; rd_in = 32'hCAFE_0000;
    rst_n = 1'b0; #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++; $display("FAIL rstmid_outputs got=%h want=0", all_outs());
    end
    @(negedge clk);
    ack_in = 1'b0; bus_en = 4'b1001; rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (o_id !== 2'd0 || o_bus_en !== 1'b1) begin
      failures++; $display("FAIL rstmid_regrant id=%0d bus=%b want 0,1", o_id, o_bus_en);
    end
    bus_en = '0; wr_rd = '0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_random();
    logic [70:0]  e_bus;
    logic [3:0]   e_ack;
    logic [127:0] e_rd;
    logic         e_err;
    int           j, w;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 7) == 0) bus_en[k] = ~bus_en[k];
        atomic[k] = ($urandom_range(0, 3) == 0);
        wr_rd[k]  = 1'($urandom);
        addr[32*k +: 32]    = $urandom;
        wr_data[32*k +: 32] = $urandom;
        byte_en[4*k +: 4]   = 4'($urandom);
      end
      ack_in = ($urandom_range(0, 2) == 0);
      rd_in  = $urandom;
      #1;
      e_bus = '0; e_ack = '0; e_rd = '0; e_err = 1'b0;
      if (m_owner >= 0) begin
        w = m_owner;
        e_bus = {bus_en[w], wr_rd[w], atomic[w], wr_data[32*w +: 32], addr[32*w +: 32], byte_en[4*w +: 4]};
        if (ack_in) begin
          e_ack[w] = 1'b1; e_rd[32*w +: 32] = rd_in;
        end else if (bus_en[w] && m_waited == TMO - 1) begin
          e_ack[w] = 1'b1; e_rd[32*w +: 32] = 32'hDEAD_BEEF; e_err = 1'b1;
        end
      end
      checks++;
      if (o_id !== m_id) begin
        failures++; $display("FAIL rnd_id cyc=%0d got=%0d want=%0d", c, o_id, m_id);
      end
      checks++;
      if ({o_bus_en, o_wr_en, o_atomic, o_wr_data, o_addr, o_byte_en} !== e_bus) begin
        failures++; $display("FAIL rnd_bus cyc=%0d got=%h want=%h", c,
          {o_bus_en, o_wr_en, o_atomic, o_wr_data, o_addr, o_byte_en}, e_bus);
      end
      checks++;
      if (o_ack !== e_ack) begin
        failures++; $display("FAIL rnd_ack cyc=%0d got=%b want=%b", c, o_ack, e_ack);
      end
      checks++;
      if (o_rd_data !== e_rd) begin
        failures++; $display("FAIL rnd_rd cyc=%0d got=%h want=%h", c, o_rd_data, e_rd);
      end
      checks++;
      if (o_timeout_err !== e_err) begin
        failures++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", c, o_timeout_err, e_err);
      end
      // advance the model to the next cycle
      if (m_gap) begin
        m_gap = 0;
      end else if (m_owner < 0) begin
        for (int s = 1; s <= 4 && m_owner < 0; s++) begin
          j = (m_last + s) % 4;
          if (bus_en[j]) begin
            m_owner = j; m_last = j; m_id = 2'(j); m_waited = 0;
          end
        end
      end else if (ack_in) begin
        if (atomic[m_owner]) m_waited = 0;
        else begin m_owner = -1; m_gap = 1; end
      end else if (!bus_en[m_owner] || m_waited == TMO - 1) begin
        m_owner = -1; m_gap = 1;
      end else begin
        m_waited++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b1; bus_en = '0; wr_rd = '0; atomic = '0; ack_in = 1'b0; rd_in = '0;
    set_fields();
    @(negedge clk);
    test_reset();
    test_priority();
    test_rotation();
    test_atomic();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
